// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
// State encoding, bus widths and the all-lanes select constant.
package mem_bus_arb_pkg;

  localparam int XLEN = 32;
  localparam int SELW = 4;

  localparam logic [SELW-1:0] SEL_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_INST,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [SELW-1:0] sel;
  } bus_req_t;

  function automatic bus_req_t inst_req(
    input logic [XLEN-1:0] addr
  );
    bus_req_t r;
    r.we    = 1'b0;
    r.addr  = addr;
    r.wdata = '0;
    r.sel   = SEL_ALL;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arb.sv
// Arbitrates core fetch and data accesses onto one shared memory bus.
// Data access goes first; a bounded wait counter turns a lost ack into an error.
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_ce_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic [XLEN-1:0] inst_data_o,
  input  logic            data_ce_i,
  input  logic            data_we_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic [XLEN-1:0] data_wdata_i,
  input  logic [SELW-1:0] data_sel_i,
  output logic [XLEN-1:0] data_rdata_o,
  output logic            stallreq_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [XLEN-1:0] bus_wdata_o,
  output logic [SELW-1:0] bus_sel_o,
  input  logic            bus_ack_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  output logic            bus_err_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  bus_req_t        req_q, req_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] drd_q, drd_d;

  logic            busy;
  logic            tmo;
  logic            xfer_end;
  logic [XLEN-1:0] cap;
  bus_req_t        data_req;

  always_comb begin
    busy     = (state_q == ST_DATA) || (state_q == ST_INST);
    // An ack in the timeout cycle still counts as a normal completion.
    tmo      = busy && !bus_ack_i && (cnt_q == CW'(WAIT_MAX - 1));
    xfer_end = busy && (bus_ack_i || tmo);
    cap      = bus_ack_i ? bus_rdata_i : '0;
    data_req.we    = data_we_i;
    data_req.addr  = data_addr_i;
    data_req.wdata = data_wdata_i;
    data_req.sel   = data_sel_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    inst_d  = inst_q;
    drd_d   = drd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (data_ce_i) begin
          state_d = ST_DATA;
          req_d   = data_req;
          cnt_d   = '0;
        end else if (inst_ce_i) begin
          state_d = ST_INST;
          req_d   = inst_req(inst_addr_i);
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (xfer_end) begin
          if (!req_q.we) drd_d = cap;
          if (inst_ce_i) begin
            state_d = ST_INST;
            req_d   = inst_req(inst_addr_i);
            cnt_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_INST: begin
        if (xfer_end) begin
          inst_d  = cap;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      inst_q  <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      inst_q  <= inst_d;
      drd_q   <= drd_d;
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    unique case (state_q)
      ST_IDLE: stallreq_o = inst_ce_i | data_ce_i;
      ST_DATA: stallreq_o = 1'b1;
      ST_INST: stallreq_o = 1'b1;
      ST_DONE: stallreq_o = 1'b0;
      default: stallreq_o = 1'b0;
    endcase
  end

  assign bus_req_o    = busy;
  assign bus_err_o    = tmo;
  assign bus_we_o     = req_q.we;
  assign bus_addr_o   = req_q.addr;
  assign bus_wdata_o  = req_q.wdata;
  assign bus_sel_o    = req_q.sel;
  assign inst_data_o  = inst_q;
  assign data_rdata_o = drd_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Randomized bench for mem_bus_arb: bench acts as core and bus slave,
// predicting bus requests, stall length and captures per transaction.
module tb_mem_bus_arb;

  localparam int WM = 16;

  logic        clk;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_rdata_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  mem_bus_arb #(.WAIT_MAX(WM)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_ce_i    (inst_ce_i),
    .inst_addr_i  (inst_addr_i),
    .inst_data_o  (inst_data_o),
    .data_ce_i    (data_ce_i),
    .data_we_i    (data_we_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_sel_i   (data_sel_i),
    .data_rdata_o (data_rdata_o),
    .stallreq_o   (stallreq_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_sel_o    (bus_sel_o),
    .bus_ack_i    (bus_ack_i),
    .bus_rdata_i  (bus_rdata_i),
    .bus_err_o    (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          d;
    logic [31:0] rd;
    bit          is_inst;
  } req_t;

  req_t        q[$];
  int          checks;
  int          failures;
  logic [31:0] exp_inst;
  logic [31:0] exp_drd;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int dur(input int d);
    return (d < WM) ? d + 1 : WM;
  endfunction

  task automatic run_txn(
    input bit dce, input bit we, input logic [31:0] daddr,
    input logic [31:0] wdata, input logic [3:0] sel,
    input int dd, input logic [31:0] drd,
    input bit ice, input logic [31:0] iaddr,
    input int id, input logic [31:0] ird);
    req_t cur;
    int   exp_stall;
    int   stall_cnt;
    int   cyc;
    int   guard;
    bit   fin;
    bit   err_exp;
    q.delete();
    exp_stall = 1;
    if (dce) begin
      q.push_back('{we, daddr, wdata, sel, dd, drd, 1'b0});
      exp_stall += dur(dd);
    end
    if (ice) begin
      q.push_back('{1'b0, iaddr, 32'h0, 4'hF, id, ird, 1'b1});
      exp_stall += dur(id);
    end
    @(negedge clk);
    data_ce_i    = dce;
    data_we_i    = we;
    data_addr_i  = daddr;
    data_wdata_i = wdata;
    data_sel_i   = sel;
    inst_ce_i    = ice;
    inst_addr_i  = iaddr;
    bus_ack_i    = 1'b0;
    #1;
    chk("idle_stall", {31'b0, stallreq_o}, 32'd1);
    chk("idle_req", {31'b0, bus_req_o}, 32'd0);
    stall_cnt = 1;
    cyc       = 0;
    guard     = 0;
    fin       = 0;
    cur       = '{1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0};
    while (!fin && guard < 200) begin
      guard++;
      @(negedge clk);
      if (bus_req_o) begin
        if (cyc == 0) begin
          if (q.size() == 0) begin
            chk("extra_req", 32'd1, 32'd0);
            cur = '{1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b1};
          end else begin
            cur = q.pop_front();
          end
        end
        chk("bus_we", {31'b0, bus_we_o}, {31'b0, cur.we});
        chk("bus_addr", bus_addr_o, cur.addr);
        chk("bus_wdata", bus_wdata_o, cur.wdata);
        chk("bus_sel", {28'b0, bus_sel_o}, {28'b0, cur.sel});
        cyc++;
        bus_ack_i   = (cur.d < WM) && (cyc == cur.d + 1);
        bus_rdata_i = bus_ack_i ? cur.rd : $urandom;
        err_exp     = (cur.d >= WM) && (cyc == WM);
        #1;
        chk("bus_err", {31'b0, bus_err_o}, {31'b0, err_exp});
        chk("busy_stall", {31'b0, stallreq_o}, 32'd1);
        stall_cnt++;
        if (bus_ack_i || err_exp) begin
          if (cur.is_inst) exp_inst = bus_ack_i ? cur.rd : 32'h0;
          else if (!cur.we) exp_drd = bus_ack_i ? cur.rd : 32'h0;
          cyc = 0;
        end
      end else begin
        bus_ack_i = 1'b0;
        #1;
        if (!stallreq_o) fin = 1;
        else stall_cnt++;
      end
    end
    if (!fin) chk("txn_timeout", 32'd0, 32'd1);
    chk("stall_len", stall_cnt, exp_stall);
    chk("reqs_left", q.size(), 32'd0);
    chk("done_err", {31'b0, bus_err_o}, 32'd0);
    chk("inst_data", inst_data_o, exp_inst);
    chk("data_rdata", data_rdata_o, exp_drd);
    data_ce_i = 1'b0;
    inst_ce_i = 1'b0;
    bus_ack_i = 1'b0;
  endtask

  task automatic spurious_ack();
    @(negedge clk);
    data_ce_i   = 1'b0;
    inst_ce_i   = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = $urandom;
    #1;
    chk("spur_stall", {31'b0, stallreq_o}, 32'd0);
    chk("spur_req", {31'b0, bus_req_o}, 32'd0);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    chk("spur_inst", inst_data_o, exp_inst);
    chk("spur_drd", data_rdata_o, exp_drd);
  endtask

  task automatic reset_mid_inst();
    @(negedge clk);
    inst_ce_i   = 1'b1;
    inst_addr_i = $urandom;
    bus_ack_i   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_req", {31'b0, bus_req_o}, 32'd1);
    rst       = 1'b0;
    inst_ce_i = 1'b0;
    #1;
    exp_inst = 32'h0;
    exp_drd  = 32'h0;
    chk("rst_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_err", {31'b0, bus_err_o}, 32'd0);
    chk("rst_stall", {31'b0, stallreq_o}, 32'd0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_sel", {28'b0, bus_sel_o}, 32'h0);
    chk("rst_inst", inst_data_o, 32'h0);
    chk("rst_drd", data_rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_req", {31'b0, bus_req_o}, 32'd0);
    chk("post_rst_inst", inst_data_o, 32'h0);
  endtask

  initial begin
    int r;
    int dd;
    int id;
    checks       = 0;
    failures     = 0;
    exp_inst     = 32'h0;
    exp_drd      = 32'h0;
    rst          = 1'b0;
    inst_ce_i    = 1'b0;
    inst_addr_i  = 32'h0;
    data_ce_i    = 1'b0;
    data_we_i    = 1'b0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    data_sel_i   = 4'h0;
    bus_ack_i    = 1'b0;
    bus_rdata_i  = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req", {31'b0, bus_req_o}, 32'd0);
    chk("reset_err", {31'b0, bus_err_o}, 32'd0);
    chk("reset_addr", bus_addr_o, 32'h0);
    chk("reset_inst", inst_data_o, 32'h0);
    chk("reset_drd", data_rdata_o, 32'h0);
    chk("reset_stall", {31'b0, stallreq_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_txn(0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 2, 32'h3C010101);
    run_txn(1, 0, 32'h100, 32'h0, 4'hF, 0, 32'hDEADBEEF,
            1, 32'h14, 0, 32'h8C220000);
    run_txn(1, 1, 32'h200, 32'h12345678, 4'b0011, 0, 32'hA5A5A5A5,
            0, 0, 0, 0);
    run_txn(0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 99, 32'h11111111);
    run_txn(1, 0, 32'h300, 32'h0, 4'hF, 99, 32'h22222222,
            1, 32'h24, WM - 1, 32'h33333333);
    spurious_ack();
    reset_mid_inst();
    run_txn(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 32'h0BADF00D);

    for (int n = 0; n < 120; n++) begin
      r  = $urandom_range(7, 0);
      dd = (r < 4) ? r : (r < 7) ? $urandom_range(WM - 1, 0)
                                 : $urandom_range(WM + 4, WM);
      r  = $urandom_range(7, 0);
      id = (r < 4) ? r : (r < 7) ? $urandom_range(WM - 1, 0)
                                 : $urandom_range(WM + 4, WM);
      r  = $urandom_range(2, 0);
      run_txn(r != 0, $urandom_range(1, 0), $urandom, $urandom,
              4'($urandom_range(15, 1)), dd, $urandom,
              r != 1, $urandom, id, $urandom);
      if ($urandom_range(9, 0) == 0) spurious_ack();
      if ($urandom_range(19, 0) == 0) reset_mid_inst();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
